ahb3lite_burst_mem_slave: RTL

- AHB-Lite subordinate (slave) memory: the responder end of the transfers our tests drive through `ahb_if.transfer()`.
- Services single and burst transfers (SINGLE, INCR, INCR4/8/16, WRAP4/8/16) with byte, halfword and word sizes.
- Inserts a programmable number of wait states.
- Polices burst address sequencing and returns the two-cycle AHB ERROR response on any protocol or range violation.
- Sits behind the address decoder as the memory target in the smoke-test harness.

---
 rtl/ahb3lite_burst_mem_slave_pkg.sv | 83 ++++++++
 rtl/ahb3lite_burst_mem_slave_tracker.sv | 61 ++++++
 rtl/ahb3lite_burst_mem_slave.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/ahb3lite_burst_mem_slave_pkg.sv
// Shared AHB-Lite encodings, FSM state encoding and burst address helpers
// for the burst memory subordinate.
package ahb3lite_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_B8    = 3'd0,
        HSIZE_B16   = 3'd1,
        HSIZE_B32   = 3'd2,
        HSIZE_B64   = 3'd3,
        HSIZE_B128  = 3'd4,
        HSIZE_B256  = 3'd5,
        HSIZE_B512  = 3'd6,
        HSIZE_B1024 = 3'd7
    } hsize_e;

    typedef enum logic [2:0] {
        HBURST_SINGLE = 3'd0,
        HBURST_INCR   = 3'd1,
        HBURST_WRAP4  = 3'd2,
        HBURST_INCR4  = 3'd3,
        HBURST_WRAP8  = 3'd4,
        HBURST_INCR8  = 3'd5,
        HBURST_WRAP16 = 3'd6,
        HBURST_INCR16 = 3'd7
    } hburst_e;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_e;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ERR1 = 2'd2;
    localparam logic [1:0] ST_ERR2 = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_WAIT = ST_WAIT,
        S_ERR1 = ST_ERR1,
        S_ERR2 = ST_ERR2
    } state_e;

    // Zero means an unbounded (INCR) burst.
    function automatic logic [4:0] burst_beats(input logic [2:0] hburst);
        case (hburst)
            HBURST_SINGLE:               return 5'd1;
            HBURST_WRAP4, HBURST_INCR4:  return 5'd4;
            HBURST_WRAP8, HBURST_INCR8:  return 5'd8;
            HBURST_WRAP16, HBURST_INCR16: return 5'd16;
            default:                     return 5'd0;
        endcase
    endfunction

    function automatic logic [31:0] next_burst_addr(input logic [31:0] addr,
                                                    input logic [2:0]  hsize,
                                                    input logic [2:0]  hburst);
        logic [31:0] bytes;
        logic [31:0] bound;
        bytes = 32'd1 << hsize;
        bound = 32'(burst_beats(hburst)) * bytes;
        if (hburst == HBURST_WRAP4 || hburst == HBURST_WRAP8 || hburst == HBURST_WRAP16)
            return (addr & ~(bound - 32'd1)) | ((addr + bytes) & (bound - 32'd1));
        return addr + bytes;
    endfunction

    // Little-endian byte-lane enables for a legal (aligned) transfer.
    function automatic logic [3:0] byte_lanes(input logic [2:0] hsize, input logic [1:0] lo);
        case (hsize)
            HSIZE_B8:  return 4'b0001 << lo;
            HSIZE_B16: return lo[1] ? 4'b1100 : 4'b0011;
            default:   return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/ahb3lite_burst_mem_slave_tracker.sv
// Burst context register: remembers the opening NONSEQ and flags any SEQ beat
// whose type, size, beat count or address breaks the burst.
module ahb3lite_burst_tracker
    import ahb3lite_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              accept,
    input  logic              illegal,
    input  logic [1:0]        htrans,
    input  logic [ADDR_W-1:0] haddr,
    input  logic [2:0]        hsize,
    input  logic [2:0]        hburst,
    output logic              seq_err
);

    logic              active_q;
    logic [2:0]        burst_q;
    logic [2:0]        size_q;
    logic [4:0]        beats_q;
    logic [4:0]        beat_q;
    logic [ADDR_W-1:0] next_addr_q;
    logic [ADDR_W-1:0] next_addr;

    assign next_addr = ADDR_W'(next_burst_addr(32'(haddr), hsize, hburst));

    assign seq_err = (htrans == HTRANS_SEQ) &&
                     (!active_q || hburst != burst_q || hsize != size_q ||
                      (beats_q != 5'd0 && beat_q >= beats_q) ||
                      haddr != next_addr_q);

    // Any rejected phase ends the burst, so a later SEQ must be reopened by a NONSEQ.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q    <= 1'b0;
            burst_q     <= 3'd0;
            size_q      <= 3'd0;
            beats_q     <= 5'd0;
            beat_q      <= 5'd0;
            next_addr_q <= '0;
        end else if (accept) begin
            if (illegal) begin
                active_q <= 1'b0;
            end else begin
                next_addr_q <= next_addr;
                if (htrans == HTRANS_NONSEQ) begin
                    active_q <= 1'b1;
                    burst_q  <= hburst;
                    size_q   <= hsize;
                    beats_q  <= burst_beats(hburst);
                    beat_q   <= 5'd1;
                end else if (beats_q != 5'd0) begin
                    beat_q <= beat_q + 5'd1;
                end
            end
        end
    end

endmodule

// File: rtl/ahb3lite_burst_mem_slave.sv
// AHB-Lite memory subordinate: byte-lane RAM with programmable wait states,
// burst sequencing checks and the two-cycle ERROR response.
module ahb3lite_burst_mem_slave
    import ahb3lite_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 32,
    parameter int MEM_BYTES   = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    input  logic              HSEL,
    input  logic [ADDR_W-1:0] HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [2:0]        HBURST,
    input  logic [3:0]        HPROT,
    input  logic              HMASTLOCK,
    input  logic              HREADY,
    input  logic [DATA_W-1:0] HWDATA,
    output logic [DATA_W-1:0] HRDATA,
    output logic              HREADYOUT,
    output logic              HRESP
);

    localparam int         MEM_AW  = $clog2(MEM_BYTES);
    localparam int         WORDS   = MEM_BYTES / 4;
    localparam logic [2:0] WS_LAST = 3'(WAIT_STATES - 1);

    state_e             state_q, state_d;
    logic [2:0]         cnt_q, cnt_d;
    logic               accept, addr_err, seq_err, illegal;
    logic               dp_valid_q, dp_write_q;
    logic [ADDR_W-1:0]  dp_addr_q;
    logic [2:0]         dp_size_q, dp_burst_q;
    logic [1:0]         dp_trans_q;
    logic [3:0]         hprot_q;
    logic               final_cycle, wr_en, load_rdata;
    logic [3:0]         wr_be;
    logic [MEM_AW-3:0]  wr_idx, rd_idx;
    logic [DATA_W-1:0]  rd_word;
    logic [DATA_W-1:0]  mem [WORDS];
    logic               unused;

    assign accept = HSEL & HREADY & HTRANS[1];

    always_comb begin
        addr_err = 1'b0;
        if (32'(HADDR) >= 32'(MEM_BYTES))
            addr_err = 1'b1;
        if (HSIZE > HSIZE_B32)
            addr_err = 1'b1;
        if ((HSIZE == HSIZE_B16 && HADDR[0]) || (HSIZE == HSIZE_B32 && HADDR[1:0] != 2'b00))
            addr_err = 1'b1;
    end

    assign illegal = addr_err | seq_err;

    ahb3lite_burst_tracker #(.ADDR_W(ADDR_W)) u_tracker (
        .clk     (HCLK),
        .rst_n   (HRESETn),
        .accept  (accept),
        .illegal (illegal),
        .htrans  (HTRANS),
        .haddr   (HADDR),
        .hsize   (HSIZE),
        .hburst  (HBURST),
        .seq_err (seq_err)
    );

    // ERR2 is ready again, so a new address phase may be taken there just like in IDLE.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        HREADYOUT = 1'b1;
        HRESP     = HRESP_OKAY;
        unique case (state_q)
            S_IDLE, S_ERR2: begin
                if (state_q == S_ERR2)
                    HRESP = HRESP_ERROR;
                state_d = S_IDLE;
                if (accept) begin
                    if (illegal) begin
                        state_d = S_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                        cnt_d   = WS_LAST;
                    end
                end
            end
            S_WAIT: begin
                HREADYOUT = 1'b0;
                if (cnt_q == 3'd0)
                    state_d = S_IDLE;
                else
                    cnt_d = cnt_q - 3'd1;
            end
            S_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = HRESP_ERROR;
                state_d   = S_ERR2;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= S_IDLE;
            cnt_q      <= 3'd0;
            dp_valid_q <= 1'b0;
            dp_write_q <= 1'b0;
            dp_addr_q  <= '0;
            dp_size_q  <= 3'd0;
            dp_burst_q <= 3'd0;
            dp_trans_q <= 2'd0;
            hprot_q    <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                dp_valid_q <= !illegal;
                dp_write_q <= HWRITE;
                dp_addr_q  <= HADDR;
                dp_size_q  <= HSIZE;
                dp_burst_q <= HBURST;
                dp_trans_q <= HTRANS;
                hprot_q    <= HPROT;
            end else if (final_cycle) begin
                dp_valid_q <= 1'b0;
            end
        end
    end

    assign final_cycle = (state_q == S_IDLE) && dp_valid_q;
    assign wr_en       = final_cycle && dp_write_q;
    assign wr_be       = byte_lanes(dp_size_q, dp_addr_q[1:0]);
    assign wr_idx      = dp_addr_q[MEM_AW-1:2];

    always_ff @(posedge HCLK) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++)
                if (wr_be[i])
                    mem[wr_idx][8*i +: 8] <= HWDATA[8*i +: 8];
        end
    end

    // A zero-wait read issued alongside a committing write must see the new bytes.
    always_comb begin
        rd_idx  = accept ? HADDR[MEM_AW-1:2] : dp_addr_q[MEM_AW-1:2];
        rd_word = mem[rd_idx];
        if (wr_en && rd_idx == wr_idx) begin
            for (int i = 0; i < 4; i++)
                if (wr_be[i])
                    rd_word[8*i +: 8] = HWDATA[8*i +: 8];
        end
    end

    assign load_rdata = (accept && !illegal && !HWRITE && WAIT_STATES == 0) ||
                        (state_q == S_WAIT && cnt_q == 3'd0 && !dp_write_q);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            HRDATA <= '0;
        else if (load_rdata)
            HRDATA <= rd_word;
    end

    assign unused = ^{hprot_q, HMASTLOCK, dp_trans_q, dp_burst_q, dp_addr_q};

endmodule
